// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: synchronizes the receiver output, times marks/spaces in 50 us ticks,
// and drives a held one-hot button vector. Optional address filter: define IR_ADDR_CHECK_EN.
//
// state      | meaning
// IDLE       | waiting for leader mark
// LEAD_MARK  | 9 ms leader mark in progress
// LEAD_SPACE | 4.5 ms data space or 2.25 ms repeat space
// BIT_MARK   | 562 us bit mark (or final stop mark after bit 32)
// BIT_SPACE  | bit space, length encodes 0/1
// STOP       | one-cycle frame integrity check
// RPT_MARK   | closing mark of a repeat code
module nec_ir_decoder #(
    parameter int          TICK_DIV    = 600,
    parameter int          HOLD_TICKS  = 2400,
    parameter logic [7:0]  REMOTE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        remote_in,
    output logic [11:0] remote_out,
    output logic        frame_valid,
    output logic [7:0]  frame_cmd,
    output logic        frame_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);

`ifdef IR_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP       = 3'd5;
    localparam logic [2:0] S_RPT_MARK   = 3'd6;

    logic          r_s1, r_s2, r_s3;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_dur;
    logic [2:0]    r_state;
    logic [5:0]    r_cnt;
    logic [31:0]   r_shift;
    logic [HW-1:0] r_hold;
    logic [11:0]   r_btn;
    logic          r_valid, r_err;
    logic [7:0]    r_cmd;

    logic          w_fall, w_rise, w_tick;
    logic [2:0]    w_nxt;
    logic          w_err, w_accept, w_rpt, w_shift, w_bit, w_cnt_clr;
    logic [7:0]    w_addr, w_addr_n, w_cmd, w_cmd_n;
    logic          w_addr_ok, w_frame_ok;

    function automatic logic in_rng(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    function automatic logic [11:0] btn_map(input logic [7:0] c);
        case (c)
            8'h18:   return 12'h001;
            8'h52:   return 12'h002;
            8'h08:   return 12'h004;
            8'h5A:   return 12'h008;
            8'h1C:   return 12'h010;
            8'h16:   return 12'h020;
            8'h45:   return 12'h040;
            8'h46:   return 12'h080;
            8'h47:   return 12'h100;
            8'h44:   return 12'h200;
            8'h40:   return 12'h400;
            8'h43:   return 12'h800;
            default: return 12'h000;
        endcase
    endfunction

    assign w_fall   = r_s3 & ~r_s2;
    assign w_rise   = ~r_s3 & r_s2;
    assign w_tick   = (r_pre == PW'(TICK_DIV - 1));
    assign w_addr   = r_shift[7:0];
    assign w_addr_n = r_shift[15:8];
    assign w_cmd    = r_shift[23:16];
    assign w_cmd_n  = r_shift[31:24];
    assign w_addr_ok  = !ADDR_CHECK || (w_addr == REMOTE_ADDR);
    assign w_frame_ok = (w_cmd == ~w_cmd_n) && (w_addr == ~w_addr_n) && w_addr_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1  <= 1'b1;
            r_s2  <= 1'b1;
            r_s3  <= 1'b1;
            r_pre <= '0;
            r_dur <= '0;
        end else begin
            r_s1  <= remote_in;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_fall || w_rise)
                r_dur <= '0;
            else if (w_tick && r_dur != 8'd255)
                r_dur <= r_dur + 1'b1;
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_err     = 1'b0;
        w_accept  = 1'b0;
        w_rpt     = 1'b0;
        w_shift   = 1'b0;
        w_bit     = 1'b0;
        w_cnt_clr = 1'b0;
        case (r_state)
            S_IDLE:
                if (w_fall) w_nxt = S_LEAD_MARK;
            S_LEAD_MARK:
                if (w_rise) begin
                    if (in_rng(r_dur, 8'd160, 8'd200)) w_nxt = S_LEAD_SPACE;
                    else w_err = 1'b1;
                end
            S_LEAD_SPACE:
                if (w_fall) begin
                    if (in_rng(r_dur, 8'd80, 8'd100)) begin
                        w_nxt     = S_BIT_MARK;
                        w_cnt_clr = 1'b1;
                    end else if (in_rng(r_dur, 8'd40, 8'd50)) begin
                        w_nxt = S_RPT_MARK;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            S_BIT_MARK:
                if (w_rise) begin
                    if (in_rng(r_dur, 8'd8, 8'd15)) w_nxt = (r_cnt == 6'd32) ? S_STOP : S_BIT_SPACE;
                    else w_err = 1'b1;
                end
            S_BIT_SPACE:
                if (w_fall) begin
                    w_nxt = S_BIT_MARK;
                    if (in_rng(r_dur, 8'd8, 8'd15)) begin
                        w_shift = 1'b1;
                    end else if (in_rng(r_dur, 8'd28, 8'd38)) begin
                        w_shift = 1'b1;
                        w_bit   = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            S_STOP: begin
                w_nxt = S_IDLE;
                if (w_frame_ok) w_accept = 1'b1;
                else w_err = 1'b1;
            end
            S_RPT_MARK:
                if (w_rise) begin
                    w_nxt = S_IDLE;
                    if (in_rng(r_dur, 8'd8, 8'd15)) w_rpt = 1'b1;
                    else w_err = 1'b1;
                end
            default: w_nxt = S_IDLE;
        endcase
        // A stuck line (no edge for 255 ticks) aborts any frame in progress.
        if (r_state != S_IDLE && r_dur == 8'd255) begin
            w_err    = 1'b1;
            w_accept = 1'b0;
            w_rpt    = 1'b0;
            w_shift  = 1'b0;
        end
        if (w_err) w_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cmd   <= '0;
        end else begin
            r_state <= w_nxt;
            r_valid <= w_accept;
            r_err   <= w_err;
            if (w_cnt_clr) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_shift) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= {w_bit, r_shift[31:1]};
            end
            if (w_accept) r_cmd <= w_cmd;
        end
    end

    // Reload (frame or repeat) takes priority over expiry in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= '0;
            r_btn  <= '0;
        end else if (w_accept) begin
            r_hold <= HW'(HOLD_TICKS);
            r_btn  <= btn_map(w_cmd);
        end else if (w_rpt && r_btn != 12'h000) begin
            r_hold <= HW'(HOLD_TICKS);
        end else begin
            if (r_hold == '0)
                r_btn <= '0;
            else if (w_tick)
                r_hold <= r_hold - 1'b1;
        end
    end

    assign remote_out  = r_btn;
    assign frame_valid = r_valid;
    assign frame_cmd   = r_cmd;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder with a shortened tick (2 clk per tick) so whole
// frames, repeats and the 120 ms hold fit in a short run.
module tb_nec_ir_decoder;

    localparam int TD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        remote_in = 1'b1;
    logic [11:0] remote_out;
    logic        frame_valid;
    logic [7:0]  frame_cmd;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int n_err = 0;
    bit gap_win = 1'b0;
    bit saw_zero = 1'b0;
    int v0, e0;

    nec_ir_decoder #(.TICK_DIV(TD), .HOLD_TICKS(2400), .REMOTE_ADDR(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .remote_in   (remote_in),
        .remote_out  (remote_out),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (gap_win && remote_out == 12'h000) saw_zero = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic ir(input logic lvl, input int ticks);
        remote_in = lvl;
        repeat (ticks * TD) @(negedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] a, input logic [7:0] an,
                              input logic [7:0] c, input logic [7:0] cn);
        logic [31:0] d;
        d = {cn, c, an, a};
        ir(1'b0, 180);
        ir(1'b1, 90);
        for (int i = 0; i < 32; i++) begin
            ir(1'b0, 11);
            ir(1'b1, d[i] ? 34 : 11);
        end
        ir(1'b0, 11);
        ir(1'b1, 10);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c);
        send_bytes(a, ~a, c, ~c);
    endtask

    task automatic send_repeat();
        ir(1'b0, 180);
        ir(1'b1, 45);
        ir(1'b0, 11);
        ir(1'b1, 10);
    endtask

    task automatic mark_counts();
        v0 = n_valid;
        e0 = n_err;
    endtask

    initial begin
        repeat (10) @(negedge clk);
        chk("rst_out", 32'(remote_out), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_cmd", 32'(frame_cmd), 32'h0);
        reset = 1'b1;
        ir(1'b1, 20);

        mark_counts();
        send_frame(8'h00, 8'h18);
        chk("f18_valid", 32'(n_valid - v0), 32'd1);
        chk("f18_err", 32'(n_err - e0), 32'd0);
        chk("f18_cmd", 32'(frame_cmd), 32'h18);
        chk("f18_out", 32'(remote_out), 32'h001);

        mark_counts();
        ir(1'b1, 800);
        send_repeat();
        ir(1'b1, 1920);
        send_repeat();
        ir(1'b1, 1920);
        chk("rpt_held_mid", 32'(remote_out), 32'h001);
        send_repeat();
        ir(1'b1, 2300);
        chk("rpt_held_end", 32'(remote_out), 32'h001);
        chk("rpt_no_valid", 32'(n_valid - v0), 32'd0);
        ir(1'b1, 200);
        chk("rpt_released", 32'(remote_out), 32'h000);

        mark_counts();
        send_bytes(8'h00, 8'hFF, 8'h45, 8'hBB);
        chk("bad_inv_err", 32'(n_err - e0), 32'd1);
        chk("bad_inv_valid", 32'(n_valid - v0), 32'd0);
        chk("bad_inv_out", 32'(remote_out), 32'h000);

        mark_counts();
        ir(1'b0, 140);
        ir(1'b1, 200);
        chk("lead7_err", 32'(n_err - e0), 32'd1);

        mark_counts();
        ir(1'b0, 180);
        ir(1'b1, 90);
        ir(1'b0, 11);
        ir(1'b1, 20);
        ir(1'b0, 11);
        ir(1'b1, 200);
        chk("space1ms_err", 32'(n_err - e0), 32'd1);

        mark_counts();
        send_frame(8'h00, 8'h1C);
        chk("f1c_valid", 32'(n_valid - v0), 32'd1);
        chk("f1c_out", 32'(remote_out), 32'h010);
        chk("f1c_cmd", 32'(frame_cmd), 32'h1C);

        send_frame(8'h00, 8'h18);
        chk("f18b_out", 32'(remote_out), 32'h001);
        saw_zero = 1'b0;
        gap_win = 1'b1;
        send_frame(8'h00, 8'h43);
        gap_win = 1'b0;
        chk("f43_out", 32'(remote_out), 32'h800);
        chk("f43_no_gap", 32'(saw_zero), 32'd0);

        ir(1'b1, 2500);
        chk("f43_expired", 32'(remote_out), 32'h000);
        mark_counts();
        send_repeat();
        ir(1'b1, 20);
        chk("rpt_idle_out", 32'(remote_out), 32'h000);
        chk("rpt_idle_valid", 32'(n_valid - v0), 32'd0);
        chk("rpt_idle_err", 32'(n_err - e0), 32'd0);

        mark_counts();
        send_frame(8'h00, 8'h99);
        chk("f99_valid", 32'(n_valid - v0), 32'd1);
        chk("f99_out", 32'(remote_out), 32'h000);
        chk("f99_cmd", 32'(frame_cmd), 32'h99);

        mark_counts();
        send_frame(8'h04, 8'h18);
`ifdef IR_ADDR_CHECK_EN
        chk("addr04_err", 32'(n_err - e0), 32'd1);
        chk("addr04_out", 32'(remote_out), 32'h000);
`else
        chk("addr04_valid", 32'(n_valid - v0), 32'd1);
        chk("addr04_out", 32'(remote_out), 32'h001);
`endif

        send_frame(8'h00, 8'h5A);
        chk("f5a_out", 32'(remote_out), 32'h008);
        ir(1'b0, 180);
        ir(1'b1, 90);
        ir(1'b0, 11);
        ir(1'b1, 34);
        remote_in = 1'b0;
        repeat (5 * TD) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_out", 32'(remote_out), 32'h000);
        chk("rstmid_cmd", 32'(frame_cmd), 32'h00);
        chk("rstmid_valid", 32'(frame_valid), 32'h0);
        remote_in = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        ir(1'b1, 300);
        send_frame(8'h00, 8'h47);
        chk("f47_out", 32'(remote_out), 32'h100);
        chk("f47_cmd", 32'(frame_cmd), 32'h47);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
